pueo_uram_readout_buffer: RTL and testbench

Elastic buffer between the per-channel UltraRAM sample buffer and the event readout path, entirely in the memclk domain. Accepts 72-bit words (6 samples × 12 bits) from the URAM read port. That port is valid-only: words already in flight cannot be stopped. The block therefore advertises readiness early, with a fixed slot margin, and re-presents the words as a true AXI4-Stream with `tlast` framing. It also flags any word that arrives with no free slot.

---
 rtl/pueo_uram_pkg.sv | 9 +
 rtl/pueo_sync_fifo.sv | 47 ++++
 rtl/pueo_uram_readout_buffer.sv | 93 +++++++++
 tb/tb_pueo_uram_readout_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_uram_pkg.sv
// Shared constants and types for the PUEO UltraRAM sample path.
// A URAM word packs six 12-bit samples.
package pueo_uram_pkg;
  localparam int URAM_SAMPLES_PER_WORD = 6;
  localparam int URAM_WORD_BITS        = 72;
  localparam int URAM_READ_MARGIN      = 5;

  typedef logic [URAM_WORD_BITS-1:0] uram_word_t;
endpackage

// File: rtl/pueo_sync_fifo.sv
// Synchronous circular FIFO with an extra pointer bit for full/empty.
// Both the head entry and the entry behind it can be read without a clock edge.
module pueo_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 72
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_head,
  output logic [WIDTH-1:0]       o_next,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [AW-1:0]    w_next_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + CW'(1);
      if (i_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign w_next_addr = r_rptr[AW-1:0] + AW'(1);
  assign o_head      = r_mem[r_rptr[AW-1:0]];
  assign o_next      = r_mem[w_next_addr];
  assign o_count     = r_wptr - r_rptr;
  assign o_full      = (o_count == CW'(DEPTH));
  assign o_empty     = (o_count == '0);
endmodule

// File: rtl/pueo_uram_readout_buffer.sv
// Elastic buffer turning the valid-only URAM read stream into framed AXI4-Stream.
// Words stay in the FIFO until handshaken; the output register mirrors the head one cycle late.
module pueo_uram_readout_buffer
  import pueo_uram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MARGIN    = URAM_READ_MARGIN,
  parameter int FRAME_LEN = 1024,
  parameter int NBIT      = 12
) (
  input  logic                                  memclk,
  input  logic                                  memclk_rst_i,
  input  logic [NBIT*URAM_SAMPLES_PER_WORD-1:0] in_tdata,
  input  logic                                  in_tvalid,
  output logic                                  in_tready,
  output logic [NBIT*URAM_SAMPLES_PER_WORD-1:0] m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  overflow_o,
  output logic                                  frame_done_o
);
  localparam int WW = NBIT * URAM_SAMPLES_PER_WORD;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(FRAME_LEN);

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_kept;
  logic [CW-1:0] w_count_next;
  logic [WW-1:0] w_head;
  logic [WW-1:0] w_next;
  logic          w_push;
  logic          w_pop;

  logic          r_tvalid;
  logic [WW-1:0] r_tdata;
  logic          r_in_tready;
  logic          r_overflow;
  logic          r_frame_done;
  logic [FW-1:0] r_frame_cnt;

  pueo_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_fifo (
    .i_clk   (memclk),
    .i_rst   (memclk_rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_tdata),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_pop        = r_tvalid && m_axis_tready && !w_empty;
  assign w_push       = in_tvalid && (!w_full || w_pop);
  assign w_count_kept = w_count - CW'(w_pop);
  assign w_count_next = w_count_kept + CW'(w_push);

  // Valid only reflects entries stored before this edge, giving one cycle of latency.
  always_ff @(posedge memclk) begin
    if (memclk_rst_i) begin
      r_tvalid     <= 1'b0;
      r_in_tready  <= 1'b1;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_tvalid     <= (w_count_kept != '0);
      r_in_tready  <= (DEPTH - int'(w_count_next)) > MARGIN;
      r_frame_done <= w_pop && m_axis_tlast;
      if (in_tvalid && !w_push) r_overflow <= 1'b1;
      if (w_pop) r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  always_ff @(posedge memclk) begin
    r_tdata <= w_pop ? w_next : w_head;
  end

  assign in_tready     = r_in_tready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tvalid && (r_frame_cnt == FW'(FRAME_LEN - 1));
  assign overflow_o    = r_overflow;
  assign frame_done_o  = r_frame_done;
endmodule

// File: tb/tb_pueo_uram_readout_buffer.sv
// Bench for the URAM readout buffer: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations on ready, overflow and framing.
module tb_pueo_uram_readout_buffer;
  localparam int DEPTH     = 16;
  localparam int MARGIN    = 5;
  localparam int FRAME_LEN = 1024;
  localparam int NBIT      = 12;
  localparam int WW        = 72;

  typedef logic [WW-1:0] word_t;

  logic  memclk        = 1'b0;
  logic  memclk_rst_i  = 1'b1;
  logic  in_tvalid     = 1'b0;
  logic  m_axis_tready = 1'b0;
  word_t in_tdata      = '0;
  word_t m_axis_tdata;
  logic  in_tready;
  logic  m_axis_tvalid;
  logic  m_axis_tlast;
  logic  overflow_o;
  logic  frame_done_o;

  int testsRun  = 0;
  int failCount = 0;

  always #5 memclk = ~memclk;

  pueo_uram_readout_buffer #(
    .DEPTH     (DEPTH),
    .MARGIN    (MARGIN),
    .FRAME_LEN (FRAME_LEN),
    .NBIT      (NBIT)
  ) dut (
    .memclk        (memclk),
    .memclk_rst_i  (memclk_rst_i),
    .in_tdata      (in_tdata),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow_o    (overflow_o),
    .frame_done_o  (frame_done_o)
  );

  function automatic word_t mkWord(input int id);
    return {8'hA5, 32'(id), 32'(id * 32'h9E37 + 7)};
  endfunction

  task automatic checkOutput(input string name, input word_t actual, input word_t expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input word_t d, input logic r);
    @(posedge memclk);
    #1;
    in_tvalid     = v;
    in_tdata      = d;
    m_axis_tready = r;
  endtask

  task automatic pushWord(input int id, input logic r);
    applyStimulus(1'b1, mkWord(id), r);
    repeat (3) applyStimulus(1'b0, '0, r);
  endtask

  task automatic doReset();
    @(posedge memclk);
    #1;
    memclk_rst_i = 1'b1;
    in_tvalid    = 1'b0;
    repeat (2) @(posedge memclk);
    #1 memclk_rst_i = 1'b0;
  endtask

  // Behavioural model: a queue of stored words, each stamped with the edge it
  // was written on; a word is presented once it has sat in storage for one edge.
  word_t  qData[$];
  longint qStamp[$];
  longint edgeNo   = 0;
  int     expFrame = 0;
  logic   expValid = 1'b0;
  logic   expLast  = 1'b0;
  logic   expReady = 1'b1;
  logic   expOvf   = 1'b0;
  logic   expDone  = 1'b0;
  bit     started  = 1'b0;

  int hsCount    = 0;
  int tlastCount = 0;
  int doneCount  = 0;
  int tlastIdx[4];

  initial begin
    forever begin
      @(posedge memclk);
      edgeNo++;
      if (memclk_rst_i) begin
        started  = 1'b1;
        qData.delete();
        qStamp.delete();
        expFrame = 0;
        expOvf   = 1'b0;
        expDone  = 1'b0;
      end else begin
        bit pop, wasLast, full;
        pop     = expValid && m_axis_tready;
        wasLast = pop && expLast;
        full    = (qData.size() == DEPTH);
        if (pop) begin
          void'(qData.pop_front());
          void'(qStamp.pop_front());
          expFrame = (expFrame + 1) % FRAME_LEN;
        end
        if (in_tvalid) begin
          if (!full || pop) begin
            qData.push_back(in_tdata);
            qStamp.push_back(edgeNo);
          end else begin
            expOvf = 1'b1;
          end
        end
        expDone = wasLast;
      end
      expReady = (DEPTH - qData.size()) > MARGIN;
      expValid = (qData.size() > 0) && (qStamp[0] < edgeNo);
      expLast  = expValid && (expFrame == FRAME_LEN - 1);

      @(negedge memclk);
      if (started) begin
        checkOutput("m_tvalid", m_axis_tvalid, expValid);
        checkOutput("m_tlast", m_axis_tlast, expLast);
        checkOutput("in_tready", in_tready, expReady);
        checkOutput("overflow", overflow_o, expOvf);
        checkOutput("frame_done", frame_done_o, expDone);
        if (expValid) checkOutput("m_tdata", m_axis_tdata, qData[0]);
        if (memclk_rst_i) begin
          hsCount    = 0;
          tlastCount = 0;
          doneCount  = 0;
        end else begin
          if (m_axis_tvalid && m_axis_tready) begin
            hsCount++;
            if (m_axis_tlast) begin
              if (tlastCount < 4) tlastIdx[tlastCount] = hsCount;
              tlastCount++;
            end
          end
          if (frame_done_o) doneCount++;
        end
      end
    end
  end

  initial begin
    doReset();
    @(negedge memclk);
    checkOutput("reset_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_tlast", m_axis_tlast, 0);
    checkOutput("reset_in_tready", in_tready, 1);
    checkOutput("reset_overflow", overflow_o, 0);
    checkOutput("reset_frame_done", frame_done_o, 0);

    // Sparse words with a willing sink: one cycle of latency, no backpressure.
    applyStimulus(1'b1, mkWord(1), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("latency_not_early", m_axis_tvalid, 0);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("latency_tvalid", m_axis_tvalid, 1);
    checkOutput("latency_tdata", m_axis_tdata, mkWord(1));
    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 2; i <= 16; i++) pushWord(i, 1'b1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("sparse_in_tready", in_tready, 1);
    checkOutput("sparse_overflow", overflow_o, 0);
    checkOutput("sparse_drained", m_axis_tvalid, 0);

    // Stalled sink: early ready drop, in-flight words absorbed, then a drop.
    for (int i = 1; i <= 17; i++) begin
      pushWord(100 + i, 1'b0);
      @(negedge memclk);
      if (i == 10) checkOutput("fill10_in_tready", in_tready, 1);
      if (i == 11) checkOutput("fill11_in_tready", in_tready, 0);
      if (i == 15) checkOutput("fill15_overflow", overflow_o, 0);
      if (i == 16) checkOutput("fill16_overflow", overflow_o, 0);
      if (i == 17) checkOutput("fill17_overflow", overflow_o, 1);
    end
    repeat (30) applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("overflow_sticky", overflow_o, 1);

    // Full FIFO with push and pop together every cycle.
    doReset();
    @(negedge memclk);
    checkOutput("reset_clears_overflow", overflow_o, 0);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, mkWord(200 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge memclk);
    checkOutput("full_in_tready", in_tready, 0);
    for (int i = 17; i <= 22; i++) applyStimulus(1'b1, mkWord(200 + i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("full_pushpop_overflow", overflow_o, 0);
    checkOutput("full_pushpop_in_tready", in_tready, 0);
    repeat (30) applyStimulus(1'b0, '0, 1'b1);

    // Two frames with a randomly stalling sink.
    doReset();
    for (int i = 1; i <= 2048; i++) begin
      applyStimulus(1'b1, mkWord(1000 + i), $urandom_range(0, 3) != 0);
      repeat (3) applyStimulus(1'b0, '0, $urandom_range(0, 3) != 0);
    end
    repeat (40) applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("stream_handshakes", hsCount, 2048);
    checkOutput("stream_tlast_count", tlastCount, 2);
    checkOutput("stream_tlast_first", tlastIdx[0], 1024);
    checkOutput("stream_tlast_second", tlastIdx[1], 2048);
    checkOutput("stream_frame_done_count", doneCount, 2);

    // Reset mid-frame with overflow set, then a full frame afterwards.
    doReset();
    for (int i = 1; i <= 500; i++) pushWord(5000 + i, 1'b1);
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, mkWord(6000 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge memclk);
    checkOutput("midframe_handshakes", hsCount, 500);
    checkOutput("midframe_overflow", overflow_o, 1);
    doReset();
    @(negedge memclk);
    checkOutput("midreset_tvalid", m_axis_tvalid, 0);
    checkOutput("midreset_overflow", overflow_o, 0);
    checkOutput("midreset_in_tready", in_tready, 1);
    for (int i = 1; i <= 1024; i++) pushWord(7000 + i, 1'b1);
    repeat (10) applyStimulus(1'b0, '0, 1'b1);
    @(negedge memclk);
    checkOutput("postreset_handshakes", hsCount, 1024);
    checkOutput("postreset_tlast_count", tlastCount, 1);
    checkOutput("postreset_tlast_index", tlastIdx[0], 1024);
    checkOutput("postreset_frame_done_count", doneCount, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
